// File: rtl/div_1.sv
// Fixed-point divider: x2_fxd = floor(|t1_fxd| * 2^X2_F / |b|), restoring, one quotient bit per cycle.
// Special cases (divide by zero, negative quotient, overflow) are decided at acceptance and force the result.
module div_1 #(
    parameter int T1_W = 24,
    parameter int B_W  = 16,
    parameter int X2_W = 16,
    parameter int X2_F = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [T1_W-1:0] t1_fxd,
    input  logic [B_W-1:0]  b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [X2_W-1:0] x2_fxd,
    output logic            dz,
    output logic            neg,
    output logic            ovf
);

    localparam int DW    = T1_W + X2_F;
    localparam int CW    = ((DW > B_W + X2_W) ? DW : B_W + X2_W) + 1;
    localparam int CNT_W = $clog2(X2_W + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [B_W-1:0]    den_q, den_d;
    logic [B_W-1:0]    rem_q, rem_d;
    logic [X2_W-1:0]   nq_q, nq_d;
    logic [X2_W-1:0]   x2_q, x2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dz_q, dz_d, neg_q, neg_d, ovf_q, ovf_d;

    logic [T1_W-1:0]   t1_mag;
    logic [B_W-1:0]    b_mag;
    logic [CW-1:0]     dvd_w, den_w;
    logic              b_zero, t1_zero, sgn_diff, ovf_c;
    logic [B_W:0]      trial, diff;
    logic              ge;

    // Magnitudes keep full width so the most negative value maps to 2^(W-1) without wrapping.
    assign t1_mag   = t1_fxd[T1_W-1] ? -t1_fxd : t1_fxd;
    assign b_mag    = b[B_W-1] ? -b : b;
    assign dvd_w    = CW'(t1_mag) << X2_F;
    assign den_w    = CW'(b_mag) << X2_W;
    assign b_zero   = (b == '0);
    assign t1_zero  = (t1_fxd == '0);
    assign sgn_diff = t1_fxd[T1_W-1] ^ b[B_W-1];
    assign ovf_c    = (dvd_w >= den_w);

    // nq_q shifts dividend bits out of the MSB while quotient bits enter at the LSB.
    assign trial = {rem_q, nq_q[X2_W-1]};
    assign ge    = (trial >= {1'b0, den_q});
    assign diff  = trial - {1'b0, den_q};

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign x2_fxd    = x2_q;
    assign dz        = dz_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d = state_q;
        den_d   = den_q;
        rem_d   = rem_q;
        nq_d    = nq_q;
        x2_d    = x2_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    den_d   = b_mag;
                    // Without overflow the upper dividend part is already below the divisor.
                    rem_d   = B_W'(dvd_w >> X2_W);
                    nq_d    = dvd_w[X2_W-1:0];
                    dz_d    = b_zero;
                    neg_d   = !b_zero && sgn_diff && !t1_zero;
                    ovf_d   = !b_zero && !(sgn_diff && !t1_zero) && ovf_c;
                end
            end
            CALC: begin
                rem_d = ge ? diff[B_W-1:0] : trial[B_W-1:0];
                nq_d  = {nq_q[X2_W-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(X2_W - 1)) begin
                    state_d = DONE;
                    x2_d    = (dz_q || ovf_q) ? '1 : (neg_q ? '0 : nq_d);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            den_q   <= '0;
            rem_q   <= '0;
            nq_q    <= '0;
            x2_q    <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            den_q   <= den_d;
            rem_q   <= rem_d;
            nq_q    <= nq_d;
            x2_q    <= x2_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_div_1.sv
// Bench for div_1: directed vector table, handshake/stall and reset sequences, random ops vs arithmetic model.
module tb_div_1;

    localparam int T1_W = 24;
    localparam int B_W  = 16;
    localparam int X2_W = 16;
    localparam int X2_F = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [T1_W-1:0] t1_fxd = '0;
    logic [B_W-1:0]  b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [X2_W-1:0] x2_fxd;
    logic            dz, neg, ovf;

    int n_tests = 0;
    int n_fail  = 0;

    div_1 #(.T1_W(T1_W), .B_W(B_W), .X2_W(X2_W), .X2_F(X2_F)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .t1_fxd(t1_fxd), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .x2_fxd(x2_fxd), .dz(dz), .neg(neg), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [T1_W-1:0] t1;
        logic [B_W-1:0]  bv;
        logic [X2_W-1:0] x2;
        logic            f_dz, f_neg, f_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers.
    function automatic void model(input logic [T1_W-1:0] t, input logic [B_W-1:0] bb,
                                  output logic [X2_W-1:0] q, output logic e_dz, e_neg, e_ovf);
        longint ts, bs, n, d, qq;
        ts = longint'($signed(t));
        bs = longint'($signed(bb));
        n  = (ts < 0) ? -ts : ts;
        d  = (bs < 0) ? -bs : bs;
        e_dz = 1'b0; e_neg = 1'b0; e_ovf = 1'b0;
        if (bs == 0) begin
            e_dz = 1'b1; q = '1;
        end else if (((ts < 0) != (bs < 0)) && ts != 0) begin
            e_neg = 1'b1; q = '0;
        end else begin
            qq = (n * (longint'(1) << X2_F)) / d;
            if (qq >= (longint'(1) << X2_W)) begin
                e_ovf = 1'b1; q = '1;
            end else begin
                q = X2_W'(qq);
            end
        end
    endfunction

    // Called #1 after a rising edge with the DUT idle; returns at the same phase, DUT idle again.
    task automatic do_op(input logic [T1_W-1:0] t, input logic [B_W-1:0] bb, input int stall,
                         output logic [X2_W-1:0] q, output logic f_dz, f_neg, f_ovf);
        int lat;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; t1_fxd = t; b = bb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            t1_fxd = T1_W'($urandom); b = B_W'($urandom); in_valid = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 100);
        chk("latency", 32'(lat), 32'(X2_W));
        q = x2_fxd; f_dz = dz; f_neg = neg; f_ovf = ovf;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom); t1_fxd = T1_W'($urandom); b = B_W'($urandom);
            @(posedge clk); #1;
            chk("stall_valid_ready", {30'd0, out_valid, in_ready}, 32'd2);
            chk("stall_stable", {12'd0, x2_fxd, 1'b0, dz, neg, ovf}, {12'd0, q, 1'b0, f_dz, f_neg, f_ovf});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_handshake", {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    vec_t vecs[13];
    logic [X2_W-1:0] q;
    logic f_dz, f_neg, f_ovf;
    logic [X2_W-1:0] eq;
    logic e_dz, e_neg, e_ovf;
    logic [T1_W-1:0] rt;
    logic [B_W-1:0]  rb;
    logic seen_ov;

    initial begin
        vecs[0]  = '{24'h000800, 16'h1000, 16'h8000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{24'h000001, 16'h0003, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{24'hFFF800, 16'hF000, 16'h8000, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{24'h123456, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{24'hFFF800, 16'h1000, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{24'h001000, 16'h1000, 16'hFFFF, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{24'h000000, 16'hF000, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{24'h000FFF, 16'h1000, 16'hFFF0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{24'h800000, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{24'hFFC000, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{24'h000000, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{24'h000007, 16'h000A, 16'hB333, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{24'hFFF001, 16'hF000, 16'hFFF0, 1'b0, 1'b0, 1'b0};

        #2 rst_n = 1'b0;
        #1;
        chk("reset_state", {12'd0, x2_fxd, in_ready, out_valid, dz, neg, ovf}, {12'd0, 16'h0, 5'b10000});
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            do_op(vecs[i].t1, vecs[i].bv, i % 3, q, f_dz, f_neg, f_ovf);
            chk($sformatf("vec%0d_x2", i), 32'(q), 32'(vecs[i].x2));
            chk($sformatf("vec%0d_flags", i), {29'd0, f_dz, f_neg, f_ovf},
                {29'd0, vecs[i].f_dz, vecs[i].f_neg, vecs[i].f_ovf});
        end

        // Long stall in DONE with noisy inputs, then immediate next acceptance.
        do_op(24'h000800, 16'h1000, 5, q, f_dz, f_neg, f_ovf);
        chk("stall5_x2", 32'(q), 32'h8000);
        do_op(24'h000001, 16'h0003, 0, q, f_dz, f_neg, f_ovf);
        chk("after_stall_x2", 32'(q), 32'h5555);

        // Reset seven cycles into a divide-by-zero operation.
        in_valid = 1'b1; t1_fxd = 24'h000000; b = 16'h0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_in_calc", {12'd0, x2_fxd, in_ready, out_valid, dz, neg, ovf}, {12'd0, 16'h0, 5'b10000});
        @(posedge clk); #1 rst_n = 1'b1;
        seen_ov = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) seen_ov = 1'b1;
        end
        chk("no_valid_after_reset", 32'(seen_ov), 32'd0);

        // Acceptance on the very first rising edge after release.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        do_op(24'hFFF800, 16'hF000, 1, q, f_dz, f_neg, f_ovf);
        chk("first_edge_accept_x2", 32'(q), 32'h8000);

        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = 16'h8000;
                2: rb = B_W'($urandom_range(1, 15));
                default: rb = B_W'($urandom);
            endcase
            if ($urandom_range(0, 1) == 1 && rb != 16'h8000) rb = -rb;
            case ($urandom_range(0, 5))
                0: rt = '0;
                1: rt = 24'h800000;
                default: rt = T1_W'($urandom) >> $urandom_range(0, 23);
            endcase
            if ($urandom_range(0, 1) == 1) rt = -rt;
            model(rt, rb, eq, e_dz, e_neg, e_ovf);
            do_op(rt, rb, $urandom_range(0, 3), q, f_dz, f_neg, f_ovf);
            chk($sformatf("rand%0d_x2 t1=%h b=%h", k, rt, rb), 32'(q), 32'(eq));
            chk($sformatf("rand%0d_flags t1=%h b=%h", k, rt, rb), {29'd0, f_dz, f_neg, f_ovf},
                {29'd0, e_dz, e_neg, e_ovf});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
